// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
// Bundle between the core execute stage, the load/store sequencer and the
// word-wide synchronous data memory.
//   Request  (core -> ctrl): req_valid, req_write, req_funct3, req_addr, req_wdata
//   Response (ctrl -> core): ready, done, err, rdata
//   Memory   (ctrl <-> mem): mem_addr, mem_re, mem_we, mem_wdata, mem_rdata
// Modports:
//   slave  - the sequencer (mem_access_ctrl)
//   master - the environment around it (core request side plus data memory)
// ---------------------------------------------------------------------------
interface mem_access_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  ready;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Multi-cycle RV32I load/store sequencer (lb/lh/lw/lbu/lhu/sb/sh/sw) between
// the execute stage and a word-wide synchronous data memory.
//   Loads      : READ -> WAIT -> DONE, lane select + sign/zero extension.
//   sb / sh    : READ -> WAIT -> WRITE -> DONE (read-modify-write).
//   sw         : WRITE -> DONE.
//   Illegal op : DONE with err, no memory strobe.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_access_if.slave (request, response and memory signals)
// Parameters:
//   ADDR_WIDTH - byte address width
//   MEM_RD_LAT - memory read latency in cycles (1..4)
// Build option:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses end
//   immediately with err; otherwise they are silently aligned down.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [2:0]            r_cnt;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [31:0]           r_rdata;
  logic                  r_write;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_f3_legal;
  logic                  w_misalign;
  logic                  w_last;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_ext;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_merge;
  logic [3:0]            w_lane_en;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == 3'd1);

  always_comb begin
    w_f3_legal = 1'b0;
    if (bus.req_write)
      w_f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      w_f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   w_misalign = bus.req_addr[0];
      2'b10:   w_misalign = |bus.req_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_f3_legal || w_misalign)
            w_state_next = S_DONE;
          else if (bus.req_write && (bus.req_funct3 == 3'b010))
            w_state_next = S_WRITE;
          else
            w_state_next = S_READ;
        end
      end
      S_READ:  w_state_next = S_WAIT;
      S_WAIT:  if (w_last) w_state_next = r_write ? S_WRITE : S_DONE;
      S_WRITE: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; sw takes the store data as-is, sb/sh the merge
  always_comb begin
    bus.ready     = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (r_state)
      S_IDLE:  bus.ready = 1'b1;
      S_READ:  bus.mem_re = 1'b1;
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = (r_funct3[1:0] == 2'b10) ? r_wdata : w_merge;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = r_err;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.rdata    = r_rdata;

  // Load lane select and extension, straight off the memory read data so the
  // result is already registered when DONE is reached.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = bus.mem_rdata[7:0];
      2'b01:   w_byte = bus.mem_rdata[15:8];
      2'b10:   w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_load_ext = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
  end

  // Read-modify-write merge: replicate store data across lanes, then pick
  // per byte lane between the new data and the buffered memory word.
  assign w_lane_en   = r_funct3[0] ? (r_addr[1] ? 4'b1100 : 4'b0011)
                                   : (4'b0001 << r_addr[1:0]);
  assign w_wdata_rep = r_funct3[0] ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merge[8*gi +: 8] = w_lane_en[gi] ? w_wdata_rep[8*gi +: 8]
                                                : r_buf[8*gi +: 8];
    end
  endgenerate

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
        r_wdata  <= bus.req_wdata;
        r_write  <= bus.req_write;
        r_err    <= !w_f3_legal || w_misalign;
      end
      if (r_state == S_READ)
        r_cnt <= 3'(MEM_RD_LAT);
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_last) begin
          r_buf <= bus.mem_rdata;
          if (!r_write)
            r_rdata <= w_load_ext;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's execute stage and a word-wide synchronous data memory.
- Handles RV32I sub-word accesses: lb, lh, lw, lbu, lhu, sb, sh, sw.
  - Loads: read, then lane-select and extend.
  - Sub-word stores: read-modify-write.
  - sw: single direct write.
- While a transfer is in progress, the core stalls (holds PC) using `ready`.

Parameters:
- ADDR_WIDTH, 32, byte-address width from the core.
- MEM_RD_LAT, 1, memory read latency in cycles (legal 1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a memory instruction.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  instr[14:12] of the memory instruction.
- req_addr  in  ADDR_WIDTH  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- ready  out  1  controller idle; request accepted when req_valid & ready.
- done  out  1  one-cycle pulse at transfer completion.
- err  out  1  with done: illegal funct3 or misaligned access (see Optional Feature).
- rdata  out  32  extended load result, held until the next completed load.
- mem_addr  out  ADDR_WIDTH  word address, with low 2 bits always 0.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe, full word.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid exactly MEM_RD_LAT cycles after the mem_re cycle.

Behaviour:
- Reset: state IDLE; ready=1; done, err, mem_re and mem_we = 0; rdata, mem_addr and mem_wdata = 0.
- Reset mid-operation: abort immediately to IDLE. No mem_we may be issued after rst_n falls.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - ready=1.
  - On accept, latch addr, funct3, wdata and write.
  - Illegal funct3 → DONE with err flagged.
    - Loads legal: 000, 001, 010, 100, 101.
    - Stores legal: 000, 001, 010.
  - Store funct3=010 → WRITE.
  - Otherwise → READ.
- READ: mem_re=1, mem_addr={addr[hi:2],2'b00}; load cycle counter with MEM_RD_LAT; → WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches its last count, capture mem_rdata into the word buffer.
  - Then → DONE for a load, → WRITE for a store.
- WRITE: mem_we=1, mem_addr as above; → DONE.
  - sw: mem_wdata = wdata.
  - sb: buffer with byte lane addr[1:0] replaced by wdata[7:0].
  - sh: buffer with half-word lane addr[1] replaced by wdata[15:0].
- DONE: done=1; err as flagged; load rdata updated this cycle; → IDLE.
- Load extension, little-endian lanes:
  - lb/lh: sign-extend bit 7/15 of the selected lane.
  - lbu/lhu: zero-extend.
  - lw: whole word.
- Latency, accept at cycle T, MEM_RD_LAT=L:
  - Load: done at T+2+L.
  - sw: done at T+2.
  - sb/sh: done at T+3+L.
  - Illegal op: done at T+1, no memory strobe.
- ready is low in every non-IDLE state.
- req_valid while not ready is ignored, not queued. The core holds the request until it sees done.
- A new request may be accepted in the IDLE cycle directly following DONE. There is no accept during DONE.
- rdata is not changed by stores or errored operations.
- mem_re and mem_we are never both 1, and each is high for exactly one cycle per access.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned lh/lhu/sh (addr[0]=1) or lw/sw (addr[1:0]≠0) → DONE at T+1 with err=1.
  - No memory strobe; rdata unchanged.
- Undefined:
  - Misaligned addresses are silently aligned down: half uses addr[1] with addr[0] ignored, word ignores addr[1:0].
  - Access proceeds normally and err is only ever raised for illegal funct3.

Test Plan:
- Reset mid-RMW: sb accepted, rst_n low during WAIT → no mem_we in any later cycle; ready=1 and outputs 0 while reset is held.
- Sign/zero extension, L=1, memory word 0x80F0_7F81 at 0x100:
  - lb 0x100 → rdata 0xFFFF_FF81, done at T+3.
  - lbu 0x103 → 0x0000_0080.
  - lh 0x102 → 0xFFFF_80F0.
  - lhu 0x100 → 0x0000_7F81.
- sb RMW: word 0x1122_3344 at 0x200, sb 0x201 wdata 0xAAAA_AA55 → single mem_we with mem_wdata 0x1122_5544, done at T+4, rdata unchanged.
- sw: 0x204 wdata 0xDEAD_BEEF → mem_we at T+1 with mem_addr 0x204, no mem_re, done at T+2.
- Back-to-back/latency, MEM_RD_LAT=3:
  - lw accepted, req_valid held → next accept exactly one cycle after done.
  - done at T+5.
  - ready low for cycles T+1..T+5.
- Illegal funct3 / misalign: load funct3=011 → done+err at T+1, no strobe.
  - With MEM_MISALIGN_TRAP_EN: lw 0x102 → err=1.
  - Without it: lw 0x102 reads the word at 0x100, err=0.
